fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

- Parametrised instruction fetch unit with a DEPTH-entry prefetch FIFO; next generation of the single-register PC fetch stage.
- Issues sequential word fetches to instruction memory ahead of decode, with up to MAX_OUTST requests in flight.
- Buffers returned instructions with their PCs and presents them to decode through a valid/stall handshake.
- Handles redirects (branch/jump/trap) and flushes by discarding buffered entries and in-flight responses.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- MAX_OUTST, 2, max accepted-but-unanswered memory requests; 1..DEPTH
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- stall_f  in  1  decode not accepting; head entry held
- flush_f  in  1  discard FIFO and in-flight; halt issue until next pc_w_en
- pc_w_en  in  1  redirect; implies flush; fetch resumes at reg_pc_in
- reg_pc_in  in  32  redirect target
- mem_req_o  out  1  fetch request valid
- mem_pc_out  out  32  fetch address, word aligned
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  response valid; in request order, ≥1 cycle after grant
- instr_fetch_in  in  32  response data
- instr_valid_o  out  1  FIFO head valid
- instr_decode_out  out  32  head instruction; 0 when !instr_valid_o
- reg_pc_out  out  32  head PC; 0 when !instr_valid_o
- misalign_o  out  1  head is a misaligned-target marker (see Configuration)

## Operation
- State: fetch PC, issue-enable flag, FIFO (wr/rd pointers plus count, DEPTH+1 states), outstanding count `out`, drop count `drop`.
- Issue: mem_req_o = issue_en && (count + out < DEPTH) && (out < MAX_OUTST).
- Handshake: mem_req_o && mem_gnt_i accepts the request; fetch PC += 4 (wraps mod 2^32); out++.
- Request stability: mem_req_o and mem_pc_out hold until granted unless a redirect/flush occurs.
- Response: mem_rvalid_i decrements out.
  - If drop > 0: drop--, data discarded.
  - Otherwise push {instr_fetch_in, PC}. The PC comes from a per-request PC queue, or equivalently head-PC tracking.
- Pop: instr_valid_o && !stall_f.
- Same-cycle events: push and pop together leave count unchanged. Grant and response together leave out unchanged.
- pc_w_en:
  - count ← 0; drop ← out (after this cycle's response/grant accounting). A response in the same cycle is discarded.
  - A grant in the same cycle is counted into drop.
  - Fetch PC ← reg_pc_in; issue_en ← 1.
- flush_f without pc_w_en: same discard behaviour; issue_en ← 0. Issuing resumes only on pc_w_en.
- flush_f and pc_w_en together: behaves as pc_w_en.
- During drop > 0, new requests may still issue. Credit check uses out, which includes to-be-dropped responses.
- Reset: fetch PC = RESET_PC, issue_en = 1, count = out = drop = 0, FIFO pointers 0. Reset mid-transaction abandons in-flight requests; memory is also reset.

## Timing
- Reset-cycle outputs: mem_req_o=0, mem_pc_out=RESET_PC, instr_valid_o=0, instr_decode_out=0, reg_pc_out=0, misalign_o=0.
- First cycle after rst_i falls: mem_req_o=1, mem_pc_out=RESET_PC.
- Fill latency: grant at cycle N, rvalid at N+1 → instr_valid_o at N+2 (one cycle from rvalid to head).
- Steady state: one instruction per cycle when gnt and rvalid are continuous and MAX_OUTST ≥ 2.
- Redirect at cycle N: mem_req_o=1 with mem_pc_out=reg_pc_in at N+1; instr_valid_o=0 at N+1.
- FIFO full and out=0 with stall_f held: mem_req_o=0, head held, no overflow.

## Configuration
- FETCH_MISALIGN_EN defined:
  - Redirect to reg_pc_in[1:0]≠0 issues no fetch and sets issue_en ← 0.
  - After drop reaches 0, pushes one marker entry {instr=0, PC=reg_pc_in, misalign=1}. misalign_o=1 while it is head.
  - Issue resumes on the next pc_w_en.
- FETCH_MISALIGN_EN undefined: reg_pc_in[1:0] ignored (forced 0); misalign_o tied 0; no marker logic.

## Test plan
- Reset release, gnt=1, rvalid one cycle after grant, stall_f=0 → instr_valid_o rises 2 cycles after first grant; PCs 0x0, 0x4, 0x8… one per cycle.
- DEPTH=4, stall_f=1 held, memory always ready → exactly 4 entries buffered, then mem_req_o=0; release stall → 4 pops in order, then fetch resumes at 0x10.
- pc_w_en with reg_pc_in=0x100 while out=2 → the two returning responses are discarded; next head PC=0x100 with its own data.
- flush_f alone with 3 entries buffered → instr_valid_o=0 next cycle, mem_req_o stays 0; later pc_w_en, reg_pc_in=0x40 → fetch at 0x40.
- mem_gnt_i=0 for 5 cycles → mem_pc_out stable and mem_req_o held; no PC advance.
- FETCH_MISALIGN_EN defined, redirect to 0x102 → single head entry with misalign_o=1, PC=0x102, no memory request.

Source files
------------

// File: rtl/fetch_prefetch_if.sv
// Fetch unit bundle: redirect/flush control, instruction-memory request/response, decode-side head.
interface fetch_prefetch_if;
  logic        stall_f;
  logic        flush_f;
  logic        pc_w_en;
  logic [31:0] reg_pc_in;
  logic        mem_req_o;
  logic [31:0] mem_pc_out;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] instr_fetch_in;
  logic        instr_valid_o;
  logic [31:0] instr_decode_out;
  logic [31:0] reg_pc_out;
  logic        misalign_o;

  modport master (
    input  stall_f, flush_f, pc_w_en, reg_pc_in, mem_gnt_i, mem_rvalid_i, instr_fetch_in,
    output mem_req_o, mem_pc_out, instr_valid_o, instr_decode_out, reg_pc_out, misalign_o
  );

  modport slave (
    output stall_f, flush_f, pc_w_en, reg_pc_in, mem_gnt_i, mem_rvalid_i, instr_fetch_in,
    input  mem_req_o, mem_pc_out, instr_valid_o, instr_decode_out, reg_pc_out, misalign_o
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching instruction fetch unit: sequential word fetches ahead of decode into a DEPTH-entry FIFO.
// Optional FETCH_MISALIGN_EN: a misaligned redirect target becomes a marker entry instead of a fetch.
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fetch_prefetch_if.master bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);

  logic [31:0]   r_pc, r_resp_pc;
  logic          r_issue_en;
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt, r_out, r_drop;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_epc   [DEPTH];

  logic [31:0]   w_tgt, w_push_instr, w_push_pc;
  logic          w_tgt_mis, w_req, w_gnt, w_flush, w_valid, w_pop;
  logic          w_push_rsp, w_push_mark, w_push;
  logic [CW-1:0] w_out_nxt;

`ifdef FETCH_MISALIGN_EN
  logic          r_mark_pend;
  logic [31:0]   r_mark_pc;
  logic          r_mis [DEPTH];

  assign w_tgt        = bus.reg_pc_in;
  assign w_tgt_mis    = |bus.reg_pc_in[1:0];
  // Marker waits until every abandoned response has drained so it cannot overtake one.
  assign w_push_mark  = r_mark_pend && (r_drop == '0) && !bus.mem_rvalid_i;
  assign w_push_instr = w_push_mark ? 32'h0 : bus.instr_fetch_in;
  assign w_push_pc    = w_push_mark ? r_mark_pc : r_resp_pc;
`else
  logic w_unused;
  assign w_unused     = ^bus.reg_pc_in[1:0];
  assign w_tgt        = {bus.reg_pc_in[31:2], 2'b00};
  assign w_tgt_mis    = 1'b0;
  assign w_push_mark  = 1'b0;
  assign w_push_instr = bus.instr_fetch_in;
  assign w_push_pc    = r_resp_pc;
`endif

  // Credit counts in-flight requests so a granted response always finds a free FIFO slot.
  assign w_flush    = bus.flush_f || bus.pc_w_en;
  assign w_req      = !rst_i && r_issue_en && (({1'b0, r_cnt} + {1'b0, r_out}) < DEPTH_C)
                      && (r_out < MAXO_C);
  assign w_gnt      = w_req && bus.mem_gnt_i;
  assign w_push_rsp = bus.mem_rvalid_i && (r_drop == '0);
  assign w_push     = w_push_rsp || w_push_mark;
  assign w_valid    = !rst_i && (r_cnt != '0);
  assign w_pop      = w_valid && !bus.stall_f;
  assign w_out_nxt  = r_out + CW'(w_gnt) - CW'(bus.mem_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_issue_en <= 1'b1;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      r_out <= w_out_nxt;
      // Discarding: everything still in flight after this cycle gets dropped on return.
      if (w_flush) begin
        r_wr   <= '0;
        r_rd   <= '0;
        r_cnt  <= '0;
        r_drop <= w_out_nxt;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop)  r_rd <= r_rd + 1'b1;
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        if (bus.mem_rvalid_i && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      end
      if (bus.pc_w_en) begin
        r_pc       <= w_tgt;
        r_resp_pc  <= w_tgt;
        r_issue_en <= !w_tgt_mis;
      end else begin
        if (bus.flush_f) r_issue_en <= 1'b0;
        if (w_gnt) r_pc <= r_pc + 32'd4;
        if (w_push_rsp && !bus.flush_f) r_resp_pc <= r_resp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr[r_wr] <= w_push_instr;
      r_epc[r_wr]   <= w_push_pc;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)            r_mark_pend <= 1'b0;
    else if (w_flush)     r_mark_pend <= bus.pc_w_en && w_tgt_mis;
    else if (w_push_mark) r_mark_pend <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (bus.pc_w_en) r_mark_pc <= w_tgt;
    if (w_push)      r_mis[r_wr] <= w_push_mark;
  end

  assign bus.misalign_o = w_valid && r_mis[r_rd];
`else
  assign bus.misalign_o = 1'b0;
`endif

  assign bus.mem_req_o        = w_req;
  assign bus.mem_pc_out       = rst_i ? RESET_PC : r_pc;
  assign bus.instr_valid_o    = w_valid;
  assign bus.instr_decode_out = w_valid ? r_instr[r_rd] : 32'h0;
  assign bus.reg_pc_out       = w_valid ? r_epc[r_rd] : 32'h0;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: queue-based reference model checked every cycle, plus directed literals.
module tb_fetch_prefetch;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_if bus ();

  fetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; logic mis; } ent_t;
  typedef struct packed { logic [31:0] pc; logic drop; } req_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] rdy; } mem_t;

  ent_t        m_fifo  [$];
  req_t        m_outst [$];
  mem_t        memq    [$];
  logic [31:0] m_pc;
  logic        m_issue;
`ifdef FETCH_MISALIGN_EN
  logic        m_mark;
  logic [31:0] m_mark_pc;
`endif

  logic        rst_d, stall, flush, pcw, gnt, rv_en;
  logic [31:0] tgt;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_outst.delete();
    memq.delete();
    m_pc    = RESET_PC;
    m_issue = 1'b1;
`ifdef FETCH_MISALIGN_EN
    m_mark  = 1'b0;
`endif
  endtask

  task automatic model_step(input bit mg, input logic rv, input logic [31:0] d);
    req_t r;
    logic [31:0] t;
    bit mis;
`ifdef FETCH_MISALIGN_EN
    bit mk;
    mk = m_mark && (m_outst.size() == 0);
`endif
    if (m_fifo.size() > 0 && !stall) m_fifo.delete(0);
    if (rv && m_outst.size() > 0) begin
      r = m_outst[0];
      m_outst.delete(0);
      if (!r.drop) m_fifo.push_back({d, r.pc, 1'b0});
    end
`ifdef FETCH_MISALIGN_EN
    if (mk) begin
      m_fifo.push_back({32'h0, m_mark_pc, 1'b1});
      m_mark = 1'b0;
    end
`endif
    if (mg) begin
      m_outst.push_back({m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (flush || pcw) begin
      m_fifo.delete();
      foreach (m_outst[i]) m_outst[i].drop = 1'b1;
`ifdef FETCH_MISALIGN_EN
      m_mark = 1'b0;
`endif
    end
    if (pcw) begin
      t = tgt;
`ifdef FETCH_MISALIGN_EN
      mis = (t[1:0] != 2'b00);
      if (mis) begin
        m_mark    = 1'b1;
        m_mark_pc = t;
      end
`else
      mis = 1'b0;
      t[1:0] = 2'b00;
`endif
      m_pc    = t;
      m_issue = !mis;
    end else if (flush) begin
      m_issue = 1'b0;
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle();
    logic        rv;
    logic [31:0] d, e_instr, e_pc;
    logic        e_req, e_vld, e_mis;
    @(negedge clk);
    rst              = rst_d;
    bus.stall_f      = stall;
    bus.flush_f      = flush;
    bus.pc_w_en      = pcw;
    bus.reg_pc_in    = tgt;
    bus.mem_gnt_i    = gnt;
    rv = 1'b0;
    d  = 32'h0;
    if (!rst_d && rv_en && memq.size() > 0 && memq[0].rdy <= cyc) begin
      rv = 1'b1;
      d  = memdata(memq[0].addr);
      memq.delete(0);
    end
    bus.mem_rvalid_i   = rv;
    bus.instr_fetch_in = d;
    #1;
    e_req = !rst && m_issue && (m_fifo.size() + m_outst.size() < DEPTH)
            && (m_outst.size() < MAX_OUTST);
    e_vld = !rst && (m_fifo.size() > 0);
    e_instr = 32'h0;
    e_pc    = 32'h0;
    e_mis   = 1'b0;
    if (e_vld) begin
      e_instr = m_fifo[0].instr;
      e_pc    = m_fifo[0].pc;
      e_mis   = m_fifo[0].mis;
    end
    chk("mem_req_o", 32'(bus.mem_req_o), 32'(e_req));
    if (rst)        chk("mem_pc_out_reset", bus.mem_pc_out, RESET_PC);
    else if (e_req) chk("mem_pc_out", bus.mem_pc_out, m_pc);
    chk("instr_valid_o", 32'(bus.instr_valid_o), 32'(e_vld));
    chk("instr_decode_out", bus.instr_decode_out, e_instr);
    chk("reg_pc_out", bus.reg_pc_out, e_pc);
    chk("misalign_o", 32'(bus.misalign_o), 32'(e_mis));
    if (rst) begin
      model_reset();
    end else begin
      if (bus.mem_req_o && gnt) memq.push_back({bus.mem_pc_out, cyc + 32'd1});
      model_step(e_req && gnt, rv, d);
    end
    cyc++;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      cycle();
      if (bus.instr_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_valid_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_d = 1'b1; stall = 1'b0; flush = 1'b0; pcw = 1'b0; gnt = 1'b1; rv_en = 1'b1; tgt = 32'h0;
    bus.stall_f = 1'b0; bus.flush_f = 1'b0; bus.pc_w_en = 1'b0; bus.reg_pc_in = 32'h0;
    bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b0; bus.instr_fetch_in = 32'h0;
    model_reset();

    // Reset values, then fill latency and sequential stream
    cycle();
    chk("reset_req", 32'(bus.mem_req_o), 32'd0);
    chk("reset_pc", bus.mem_pc_out, 32'h0);
    chk("reset_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("reset_head_pc", bus.reg_pc_out, 32'h0);
    cycle();
    rst_d = 1'b0;
    cycle();
    chk("first_req", 32'(bus.mem_req_o), 32'd1);
    chk("first_pc", bus.mem_pc_out, 32'h0);
    cycle();
    chk("fill_valid_n1", 32'(bus.instr_valid_o), 32'd0);
    cycle();
    chk("fill_valid_n2", 32'(bus.instr_valid_o), 32'd1);
    chk("fill_head_pc0", bus.reg_pc_out, 32'h0);
    chk("fill_head_ins0", bus.instr_decode_out, 32'hCAFE_0000);
    cycle();
    chk("stream_pc4", bus.reg_pc_out, 32'h4);
    chk("stream_ins4", bus.instr_decode_out, 32'hCAFE_0004);
    cycle();
    chk("stream_pc8", bus.reg_pc_out, 32'h8);
    repeat (5) cycle();

    // Stall with memory always ready: FIFO fills to DEPTH then issue stops
    rst_d = 1'b1; cycle(); rst_d = 1'b0;
    stall = 1'b1;
    repeat (10) cycle();
    chk("full_req", 32'(bus.mem_req_o), 32'd0);
    chk("full_head_pc", bus.reg_pc_out, 32'h0);
    chk("full_head_ins", bus.instr_decode_out, 32'hCAFE_0000);
    stall = 1'b0;
    cycle();
    chk("drain_head0", bus.reg_pc_out, 32'h0);
    chk("drain_req0", 32'(bus.mem_req_o), 32'd0);
    cycle();
    chk("drain_head4", bus.reg_pc_out, 32'h4);
    chk("resume_req", 32'(bus.mem_req_o), 32'd1);
    chk("resume_pc", bus.mem_pc_out, 32'h10);
    repeat (6) cycle();

    // Redirect with two responses in flight
    rv_en = 1'b0;
    repeat (3) cycle();
    chk("outst_full_req", 32'(bus.mem_req_o), 32'd0);
    pcw = 1'b1; tgt = 32'h100;
    cycle();
    pcw = 1'b0; rv_en = 1'b1;
    cycle();
    chk("redir_valid_n1", 32'(bus.instr_valid_o), 32'd0);
    wait_valid(20, ok);
    chk("redir_head_pc", bus.reg_pc_out, 32'h100);
    chk("redir_head_ins", bus.instr_decode_out, 32'hCAFE_0100);
    repeat (4) cycle();

    // Flush alone with three buffered entries, then redirect to 0x40
    rst_d = 1'b1; cycle(); rst_d = 1'b0;
    stall = 1'b1; gnt = 1'b1;
    repeat (3) cycle();
    gnt = 1'b0;
    repeat (3) cycle();
    chk("pre_flush_head", bus.reg_pc_out, 32'h0);
    flush = 1'b1;
    cycle();
    flush = 1'b0; gnt = 1'b1;
    cycle();
    chk("flush_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("flush_req", 32'(bus.mem_req_o), 32'd0);
    repeat (3) cycle();
    chk("flush_req_held", 32'(bus.mem_req_o), 32'd0);
    pcw = 1'b1; tgt = 32'h40;
    cycle();
    pcw = 1'b0; gnt = 1'b0; stall = 1'b0;

    // Grant withheld: request and address must hold
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("nogrant_req", 32'(bus.mem_req_o), 32'd1);
      chk("nogrant_pc", bus.mem_pc_out, 32'h40);
    end
    gnt = 1'b1;
    cycle();
    cycle();
    chk("after_grant_pc", bus.mem_pc_out, 32'h44);
    repeat (4) cycle();

    // Misaligned redirect target
    pcw = 1'b1; tgt = 32'h102;
    cycle();
    pcw = 1'b0;
`ifdef FETCH_MISALIGN_EN
    wait_valid(20, ok);
    chk("mis_flag", 32'(bus.misalign_o), 32'd1);
    chk("mis_pc", bus.reg_pc_out, 32'h102);
    chk("mis_ins", bus.instr_decode_out, 32'h0);
    chk("mis_req", 32'(bus.mem_req_o), 32'd0);
    repeat (3) cycle();
    pcw = 1'b1; tgt = 32'h200;
    cycle();
    pcw = 1'b0;
`else
    cycle();
    chk("mis_forced_req", 32'(bus.mem_req_o), 32'd1);
    chk("mis_forced_pc", bus.mem_pc_out, 32'h100);
    wait_valid(20, ok);
    chk("mis_forced_head", bus.reg_pc_out, 32'h100);
    chk("mis_flag_off", 32'(bus.misalign_o), 32'd0);
`endif
    repeat (4) cycle();

    // Address wrap at the top of the space
    pcw = 1'b1; tgt = 32'hFFFF_FFF8;
    cycle();
    pcw = 1'b0;
    repeat (10) cycle();

    // Mixed traffic: random stalls, grant gaps, response gaps, flushes and redirects
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      gnt   = ($urandom_range(0, 3) != 0);
      rv_en = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      pcw   = ($urandom_range(0, 29) == 0);
      tgt   = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      cycle();
    end
    stall = 1'b0; flush = 1'b0; pcw = 1'b0; gnt = 1'b1; rv_en = 1'b1;
    repeat (3) cycle();

    // Reset in the middle of traffic
    rst_d = 1'b1; cycle(); rst_d = 1'b0;
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
